// File: rtl/inst_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_pkg
// Description : Shared types and constants for the fetch-to-decode
//               instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fifo_pkg;

  // One buffered fetch result: program counter plus the instruction word.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } inst_entry_t;

  // Default number of buffer entries (power of two, at least 4).
  localparam int INST_FIFO_DEPTH = 16;

endpackage : inst_fifo_pkg
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo
// Description : Dual-slot instruction buffer between fetch and dual-issue
//               decode. Accepts 0-2 pushes and 0-2 pops per cycle, keeps
//               program order, and supports a single-cycle flush.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_addr2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_addr2,
  output logic        read_valid1,
  output logic        read_valid2,
  output logic        empty,
  output logic        full
);

  // full once fewer than two slots are free, so a dual push can never overflow
  localparam logic [PTR_W:0] C_FULL_LVL = (PTR_W + 1)'(DEPTH - 2);
  localparam logic [PTR_W:0] C_ONE      = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] C_TWO      = (PTR_W + 1)'(2);

  inst_entry_t      mem_q [DEPTH];
  inst_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             w_push1, w_push2;
  logic             w_pop1, w_pop2;
  logic [PTR_W:0]   w_n_push, w_n_pop;
  logic [PTR_W-1:0] w_wptr_p1, w_rptr_p1;
  inst_entry_t      w_head0, w_head1;

  // Legality of this cycle's pushes and pops, judged on the registered count
  always_comb begin
    w_push1   = write_en1 && !full;
    w_push2   = write_en1 && write_en2 && !full;
    w_pop1    = read_en1 && (count_q >= C_ONE);
    w_pop2    = read_en1 && read_en2 && (count_q >= C_TWO);
    w_n_push  = (PTR_W + 1)'(w_push1) + (PTR_W + 1)'(w_push2);
    w_n_pop   = (PTR_W + 1)'(w_pop1) + (PTR_W + 1)'(w_pop2);
    w_wptr_p1 = wptr_q + PTR_W'(1);
    w_rptr_p1 = rptr_q + PTR_W'(1);
  end

  // Next pointer/count state; flush empties the buffer and discards traffic
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PTR_W'(w_n_push);
      rptr_d  = rptr_q + PTR_W'(w_n_pop);
      count_d = count_q + w_n_push - w_n_pop;
    end
  end

  // Next storage contents; slot 2 lands one entry after slot 1 (wrapping)
  always_comb begin
    mem_d = mem_q;
    if (!flush) begin
      if (w_push1) mem_d[wptr_q]    = '{addr: write_addr1, inst: write_inst1};
      if (w_push2) mem_d[w_wptr_p1] = '{addr: write_addr2, inst: write_inst2};
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count says they are empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read port and status, zeroed wherever the slot is invalid
  always_comb begin
    read_valid1 = (count_q >= C_ONE);
    read_valid2 = (count_q >= C_TWO);
    empty       = (count_q == '0);
    full        = (count_q > C_FULL_LVL);
    w_head0     = read_valid1 ? mem_q[rptr_q]    : '0;
    w_head1     = read_valid2 ? mem_q[w_rptr_p1] : '0;
    read_inst1  = w_head0.inst;
    read_addr1  = w_head0.addr;
    read_inst2  = w_head1.inst;
    read_addr2  = w_head1.addr;
  end

endmodule : inst_fifo
`default_nettype wire

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
Dual-slot instruction buffer between the fetch stage and the dual-issue decode stage. It is the transmitting end of the 32-bit instruction-word interface that the decoder consumes.
- Fetch pushes 0–2 {pc, instr} entries per cycle.
- Decode pops 0–2 entries per cycle, in program order.
- Flush support covers branch mispredict and exceptions.

Parameters:
DEPTH, 16, number of entries; must be a power of 2 and ≥ 4.
PTR_W, $clog2(DEPTH), pointer width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (mispredict/exception)
write_en1  in  1  push slot 1
write_en2  in  1  push slot 2; valid only together with write_en1
write_inst1  in  32  instruction word, slot 1
write_inst2  in  32  instruction word, slot 2
write_addr1  in  32  PC of slot 1
write_addr2  in  32  PC of slot 2
read_en1  in  1  decode consumes head entry
read_en2  in  1  decode consumes head+1 entry; valid only together with read_en1
read_inst1  out  32  instruction at head
read_inst2  out  32  instruction at head+1
read_addr1  out  32  PC at head
read_addr2  out  32  PC at head+1
read_valid1  out  1  head entry valid (count ≥ 1)
read_valid2  out  1  head+1 entry valid (count ≥ 2)
empty  out  1  count == 0
full  out  1  count > DEPTH-2; fetch must not push this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - wptr=0, rptr=0, count=0.
  - empty=1, full=0, read_valid1/2=0, read_inst*/read_addr* = 0.
  - Storage contents are don't-care.
- Storage: DEPTH×64-bit array. Read outputs are combinational from rptr and rptr+1 (mod DEPTH).
  - Output is 0 when the corresponding read_valid is 0.
- Write latency: an entry pushed at edge N is visible on the read_* ports after edge N (same cycle as N+1 logic). There is no write-to-read bypass.
- Push legality:
  - write_en2 without write_en1: ignored, nothing written.
  - full=1: all writes that cycle are dropped. Fetch is responsible for stalling.
  - Slot 1 writes mem[wptr]; slot 2 writes mem[wptr+1]. wptr advances by the number accepted (0/1/2), modulo DEPTH.
- Pop legality:
  - read_en1 with count==0: ignored.
  - read_en2 with count<2: only slot 1 is popped.
  - read_en2 without read_en1: ignored.
  - rptr advances by the number popped, modulo DEPTH.
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. Pop eligibility is judged on the pre-edge count, so there is no same-cycle bypass.
- full and empty are combinational from the registered count.
  - count == DEPTH−1 still asserts full, even though one slot is free.
  - Invariant: 0 ≤ count ≤ DEPTH, never violated.
- flush: highest priority after rst.
  - On flush edge: wptr=rptr=0 and count=0.
  - Pushes and pops in the same cycle are discarded.
  - Next cycle empty=1.
- Wrap-around:
  - Two-slot writes and reads straddling index DEPTH−1 → 0 must be correct.
  - This includes read_inst2 sourced from mem[0] while rptr=DEPTH−1.
- Program order: slot 1 is always older than slot 2. The FIFO never reorders.

Decomposition:
- Shared package holds:
  - typedef inst_entry_t {logic [31:0] addr; logic [31:0] inst;}
  - constant INST_FIFO_DEPTH = 16
- No sub-module. The storage is a plain register array inside inst_fifo. A separate RAM wrapper is unnecessary at this depth.

Test Plan:
1. Reset then idle → empty=1, full=0, read_valid1=read_valid2=0, read_inst1=0.
2. Push {0xBFC00000, 0x24080001} and {0xBFC00004, 0x24090002} in one cycle, no pop. Next cycle → read_inst1=0x24080001, read_addr2=0xBFC00004, read_valid2=1, count=2.
3. Fill with 7 dual pushes (count=14), then push 1 → count=15, full=1. Next dual push → dropped, count stays 15. Dual pop → count=13, full=0.
4. Steady state at count=3: dual push plus dual pop in the same cycle → count stays 3, order preserved. Run through ≥ 2 full wraps; rptr=15 gives read_inst2 from mem[0].
5. count=1 with read_en1=read_en2=1 plus dual push → only 1 popped, 2 pushed, count=2. Head is the first newly pushed entry.
6. count=5 with flush, dual push and dual pop in the same cycle → next cycle empty=1, count=0. Subsequent push of 0x00000000 at PC 0x80000000 appears at read_addr1=0x80000000.
